// File: rtl/cook_timer_ctrl.sv
`default_nettype none
// ============================================================================
// cook_timer_ctrl : keypad entry, load/count sequencing and magnetron gating
//                   for a four-digit BCD microwave countdown chain.
// Revision: 1.0
// ============================================================================
module cook_timer_ctrl #(
  parameter int TICK_DIV    = 100,
  parameter int DONE_CYCLES = 3
) (
  input  logic        clock,
  input  logic        clearn,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop,
  input  logic        door_closed,
  input  logic        timer_zero,
  output logic [15:0] load_data,
  output logic        loadn,
  output logic        count_en,
  output logic        chain_clearn,
  output logic        magnetron_on,
  output logic        done,
  output logic [2:0]  state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DONE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DONE_LAST  = DW'(DONE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_LOAD  = 3'd2,
    S_COOK  = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        cur, nxt;
  logic [15:0]   entry, entry_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic          clear_exit;
  logic          key_ok;

  assign key_ok = key_valid && (key_digit <= 4'd9);

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      cur   <= S_IDLE;
      entry <= 16'h0000;
      presc <= '0;
      dcnt  <= '0;
    end else begin
      cur   <= nxt;
      entry <= entry_nxt;
      presc <= presc_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  always_comb begin
    nxt          = cur;
    entry_nxt    = entry;
    presc_nxt    = presc;
    dcnt_nxt     = dcnt;
    clear_exit   = 1'b0;
    loadn        = 1'b1;
    count_en     = 1'b0;
    magnetron_on = 1'b0;
    done         = 1'b0;

    case (cur)
      S_IDLE: begin
        if (key_ok) begin
          nxt       = S_ENTRY;
          entry_nxt = {entry[11:0], key_digit};
        end
      end
      S_ENTRY: begin
        if (key_ok) entry_nxt = {entry[11:0], key_digit};
        if (stop) begin
          nxt        = S_IDLE;
          clear_exit = 1'b1;
        end else if (start && door_closed && (entry != 16'h0000)) begin
          nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        loadn     = 1'b0;
        nxt       = S_COOK;
        presc_nxt = '0;
      end
      S_COOK: begin
        magnetron_on = door_closed;
        // Never strobe the chain once it reads zero, or it would wrap.
        count_en = (presc == PRESC_LAST) && !timer_zero && door_closed && !stop;
        if (timer_zero) begin
          nxt = S_DONE;
        end else if (stop || !door_closed) begin
          nxt = S_PAUSE;
        end else begin
          presc_nxt = (presc == PRESC_LAST) ? '0 : presc + PW'(1);
        end
      end
      S_PAUSE: begin
        if (stop) begin
          nxt        = S_IDLE;
          clear_exit = 1'b1;
        end else if (start && door_closed) begin
          nxt = S_COOK;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (stop || (dcnt == DONE_LAST)) begin
          nxt        = S_IDLE;
          clear_exit = 1'b1;
          dcnt_nxt   = '0;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      default: nxt = S_IDLE;
    endcase

    if (clear_exit) entry_nxt = 16'h0000;
  end

  assign chain_clearn = !clear_exit;
  assign load_data    = entry;
  assign state        = cur;

endmodule
`default_nettype wire
